// File: rtl/cnn_run_sequencer.sv
// Run sequencer for the CNN layer engine: waits for image+weights loaded, steps
// every layer with a per-layer watchdog, then interrupts the CPU and clears the setting register.
module cnn_run_sequencer #(
  parameter int NUM_LAYERS     = 7,
  parameter int LAYER_W        = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         setting_done_condition,
  input  logic               layer_done,
  input  logic               irq_ack,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_index,
  output logic               busy,
  output logic               cnn_done,
  output logic               timeout_err,
  output logic               irq,
  output logic               clear_setting
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_cnt_nxt;
  logic [LAYER_W-1:0] layer_index_nxt;
  logic               cnn_done_nxt;
  logic               timeout_err_nxt;
  logic               irq_nxt;
  logic               layer_start_nxt;
  logic               busy_nxt;
  logic               clear_setting_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    to_cnt_nxt        = to_cnt;
    layer_index_nxt   = layer_index;
    cnn_done_nxt      = cnn_done;
    timeout_err_nxt   = timeout_err;
    irq_nxt           = irq;
    layer_start_nxt   = 1'b0;
    busy_nxt          = 1'b0;
    clear_setting_nxt = 1'b0;

    case (state)
      IDLE: begin
        // A pending interrupt blocks a new run until the CPU has acknowledged.
        if (setting_done_condition == 2'b11 && !irq) begin
          state_nxt = START;
        end
      end
      START: begin
        to_cnt_nxt = '0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // layer_done takes priority over the terminal count.
        if (layer_done) begin
          state_nxt = NEXT;
        end else if (to_cnt == TO_LAST) begin
          timeout_err_nxt = 1'b1;
          state_nxt       = FINISH;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      NEXT: begin
        if (layer_index == LAST_LAYER) begin
          cnn_done_nxt = 1'b1;
          state_nxt    = FINISH;
        end else begin
          layer_index_nxt = layer_index + LAYER_W'(1);
          state_nxt       = START;
        end
      end
      FINISH: begin
        state_nxt = DONE;
      end
      DONE: begin
        // layer_index stays on the last layer run until the CPU acknowledges.
        if (irq_ack) begin
          irq_nxt         = 1'b0;
          cnn_done_nxt    = 1'b0;
          timeout_err_nxt = 1'b0;
          layer_index_nxt = '0;
          state_nxt       = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    layer_start_nxt   = (state_nxt == START);
    busy_nxt          = (state_nxt inside {START, WAIT, NEXT, FINISH});
    clear_setting_nxt = (state_nxt == FINISH);
    if (state_nxt == FINISH) begin
      irq_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt        <= '0;
      layer_index   <= '0;
      layer_start   <= 1'b0;
      busy          <= 1'b0;
      cnn_done      <= 1'b0;
      timeout_err   <= 1'b0;
      irq           <= 1'b0;
      clear_setting <= 1'b0;
    end else begin
      to_cnt        <= to_cnt_nxt;
      layer_index   <= layer_index_nxt;
      layer_start   <= layer_start_nxt;
      busy          <= busy_nxt;
      cnn_done      <= cnn_done_nxt;
      timeout_err   <= timeout_err_nxt;
      irq           <= irq_nxt;
      clear_setting <= clear_setting_nxt;
    end
  end

endmodule
